// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - RTC register map, sweep address table and FSM encoding
package rtc_pkg;

  localparam logic [7:0] ADDR_SEG   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HORA  = 8'h23;
  localparam logic [7:0] ADDR_DIA   = 8'h24;
  localparam logic [7:0] ADDR_MES   = 8'h25;
  localparam logic [7:0] ADDR_ANO   = 8'h26;
  localparam logic [7:0] ADDR_SEGT  = 8'h41;
  localparam logic [7:0] ADDR_MINT  = 8'h42;
  localparam logic [7:0] ADDR_HORAT = 8'h43;

  localparam int         NUM_REGS   = 9;
  localparam logic [3:0] LAST_INDEX = 4'd8;

  // Strips the 12/24 and AM/PM flag bits from the hour registers.
  localparam logic [7:0] HOUR_MASK  = 8'h3F;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_HOLD,
    DATA,
    RECOVER,
    GRANT
  } state_t;

  function automatic logic [7:0] sweep_addr(input logic [3:0] index);
    logic [7:0] a;
    case (index)
      4'd0:    a = ADDR_SEG;
      4'd1:    a = ADDR_MIN;
      4'd2:    a = ADDR_HORA;
      4'd3:    a = ADDR_DIA;
      4'd4:    a = ADDR_MES;
      4'd5:    a = ADDR_ANO;
      4'd6:    a = ADDR_SEGT;
      4'd7:    a = ADDR_MINT;
      4'd8:    a = ADDR_HORAT;
      default: a = ADDR_SEG;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_read_sequencer_bus_cycle.sv
// rtl/rtc_read_sequencer_bus_cycle.sv - one RTC read transaction: address write, data read, recovery
module rtc_bus_cycle
  import rtc_pkg::*;
#(
  parameter logic [7:0] T_PULSE = 8'd4,
  parameter logic [7:0] T_GAP   = 8'd4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [7:0] addr,
  input  logic [7:0] ad_in,
  output logic       done,
  output logic [7:0] data,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic [7:0] ad_out,
  output logic       ad_oe
);

  state_t     phase, next_phase;
  logic [7:0] cnt, next_cnt;
  logic [7:0] addr_q, next_addr;
  logic [7:0] next_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= IDLE;
      cnt    <= 8'd0;
      addr_q <= 8'd0;
      data   <= 8'd0;
    end else begin
      phase  <= next_phase;
      cnt    <= next_cnt;
      addr_q <= next_addr;
      data   <= next_data;
    end
  end

  // go may arrive on the final RECOVER cycle so transactions chain without a gap.
  always_comb begin
    next_phase = phase;
    next_cnt   = cnt;
    next_addr  = addr_q;
    next_data  = data;
    if (go) begin
      next_phase = ADDR;
      next_cnt   = T_PULSE - 8'd1;
      next_addr  = addr;
    end else begin
      case (phase)
        ADDR: begin
          if (cnt == 8'd0) begin
            next_phase = ADDR_HOLD;
            next_cnt   = T_GAP - 8'd1;
          end else begin
            next_cnt = cnt - 8'd1;
          end
        end
        ADDR_HOLD: begin
          if (cnt == 8'd0) begin
            next_phase = DATA;
            next_cnt   = T_PULSE - 8'd1;
          end else begin
            next_cnt = cnt - 8'd1;
          end
        end
        DATA: begin
          if (cnt == 8'd0) begin
            next_data  = ad_in;
            next_phase = RECOVER;
            next_cnt   = T_GAP - 8'd1;
          end else begin
            next_cnt = cnt - 8'd1;
          end
        end
        RECOVER: begin
          if (cnt == 8'd0) begin
            next_phase = IDLE;
          end else begin
            next_cnt = cnt - 8'd1;
          end
        end
        default: next_phase = IDLE;
      endcase
    end
  end

  assign done   = (phase == RECOVER) && (cnt == 8'd0);
  assign cs_n   = !((phase == ADDR) || (phase == ADDR_HOLD) || (phase == DATA));
  assign wr_n   = !(phase == ADDR);
  assign rd_n   = !(phase == DATA);
  assign ad_n   = !((phase == ADDR) || (phase == ADDR_HOLD));
  assign ad_oe  = (phase == ADDR) || (phase == ADDR_HOLD);
  assign ad_out = ad_oe ? addr_q : 8'd0;

endmodule

// File: rtl/rtc_read_sequencer.sv
// rtl/rtc_read_sequencer.sv - periodic RTC register sweep with bus hand-off and atomic commit
module rtc_read_sequencer
  import rtc_pkg::*;
#(
  parameter logic [23:0] REFRESH_CYC = 24'd2_500_000,
  parameter logic [7:0]  T_PULSE     = 8'd4,
  parameter logic [7:0]  T_GAP       = 8'd4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       BUS_REQ,
  output logic       BUS_GNT,
  output logic       CS_N,
  output logic       RD_N,
  output logic       WR_N,
  output logic       AD_N,
  output logic [7:0] AD_OUT,
  output logic       AD_OE,
  input  logic [7:0] AD_IN,
  output logic [7:0] SEGUNDO_T,
  output logic [7:0] MINUTO_T,
  output logic [7:0] HORA_T,
  output logic [7:0] DIA_T,
  output logic [7:0] MES_T,
  output logic [7:0] ANO_T,
  output logic [7:0] SEGUNDOT_T,
  output logic [7:0] MINUTOT_T,
  output logic [7:0] HORAT_T,
  output logic       SWEEP_DONE
);

  // Here ADDR stands for "a transaction is in flight in the bus engine".
  state_t      state, next_state;
  logic [23:0] refresh_cnt;
  logic        refresh_wrap;
  logic        pending;
  logic        in_sweep;
  logic [3:0]  index;
  logic [7:0]  shadow [NUM_REGS];

  logic        go;
  logic [7:0]  go_addr;
  logic        start_sweep;
  logic        advance;
  logic        commit;
  logic        eng_done;
  logic [7:0]  eng_data;

  rtc_bus_cycle #(
    .T_PULSE (T_PULSE),
    .T_GAP   (T_GAP)
  ) u_bus_cycle (
    .clk    (CLK),
    .rst_n  (RST),
    .go     (go),
    .addr   (go_addr),
    .ad_in  (AD_IN),
    .done   (eng_done),
    .data   (eng_data),
    .cs_n   (CS_N),
    .rd_n   (RD_N),
    .wr_n   (WR_N),
    .ad_n   (AD_N),
    .ad_out (AD_OUT),
    .ad_oe  (AD_OE)
  );

  assign refresh_wrap = (refresh_cnt == REFRESH_CYC - 24'd1);
  assign BUS_GNT      = (state == GRANT);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      refresh_cnt <= 24'd0;
      pending     <= 1'b0;
    end else begin
      refresh_cnt <= refresh_wrap ? 24'd0 : refresh_cnt + 24'd1;
      if (START || refresh_wrap) begin
        pending <= 1'b1;
      end else if (start_sweep) begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    go          = 1'b0;
    go_addr     = sweep_addr(index);
    start_sweep = 1'b0;
    advance     = 1'b0;
    commit      = 1'b0;
    case (state)
      IDLE: begin
        if (BUS_REQ) begin
          next_state = GRANT;
        end else if (pending) begin
          go          = 1'b1;
          go_addr     = sweep_addr(4'd0);
          start_sweep = 1'b1;
          next_state  = ADDR;
        end
      end
      ADDR: begin
        if (eng_done) begin
          if (index == LAST_INDEX) begin
            commit     = 1'b1;
            next_state = IDLE;
          end else begin
            advance = 1'b1;
            if (BUS_REQ) begin
              next_state = GRANT;
            end else begin
              go      = 1'b1;
              go_addr = sweep_addr(index + 4'd1);
            end
          end
        end
      end
      GRANT: begin
        if (!BUS_REQ) begin
          if (in_sweep) begin
            go         = 1'b1;
            next_state = ADDR;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The last register comes straight from the engine so all nine commit on one edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      index      <= 4'd0;
      in_sweep   <= 1'b0;
      SWEEP_DONE <= 1'b0;
      SEGUNDO_T  <= 8'h00;
      MINUTO_T   <= 8'h00;
      HORA_T     <= 8'h00;
      DIA_T      <= 8'h00;
      MES_T      <= 8'h00;
      ANO_T      <= 8'h00;
      SEGUNDOT_T <= 8'h00;
      MINUTOT_T  <= 8'h00;
      HORAT_T    <= 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= 8'h00;
      end
    end else begin
      SWEEP_DONE <= commit;
      if (start_sweep) begin
        index    <= 4'd0;
        in_sweep <= 1'b1;
      end else if (advance) begin
        index <= index + 4'd1;
      end
      if (state == ADDR && eng_done) begin
        shadow[index] <= eng_data;
      end
      if (commit) begin
        in_sweep   <= 1'b0;
        SEGUNDO_T  <= shadow[0];
        MINUTO_T   <= shadow[1];
        HORA_T     <= shadow[2] & HOUR_MASK;
        DIA_T      <= shadow[3];
        MES_T      <= shadow[4];
        ANO_T      <= shadow[5];
        SEGUNDOT_T <= shadow[6];
        MINUTOT_T  <= shadow[7];
        HORAT_T    <= eng_data & HOUR_MASK;
      end
    end
  end

endmodule

// File: doc/rtc_read_sequencer.md
Name: rtc_read_sequencer

Overview:
- Upstream feeder of the VGA display stage.
- Periodically sweeps the nine RTC time, date and timer registers over the RTC's multiplexed address/data bus.
- Holds the BCD results in committed output registers, which drive DIA_T…SEGUNDOT_T of the display stage.
- Yields the bus to the RTC write/programming block through a request/grant handshake.

Parameters:
- REFRESH_CYC, 24'd2_500_000: CLK cycles between automatic sweeps (100 ms at 25 MHz).
- T_PULSE, 8'd4: cycles for which a strobe (WR_N or RD_N) is held low.
- T_GAP, 8'd4: cycles of strobe-high hold/recovery after each strobe.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse; requests an immediate sweep.
- BUS_REQ  in  1  write block requests the RTC bus.
- BUS_GNT  out  1  bus handed to write block; all strobes released.
- CS_N, RD_N, WR_N, AD_N  out  1 each  RTC bus strobes (AD_N=0 address phase, 1 data phase).
- AD_OUT  out  8  address driven on bus.
- AD_OE  out  1  tristate enable for AD_OUT (tristate buffer lives at top level).
- AD_IN  in  8  bus read data.
- SEGUNDO_T, MINUTO_T, HORA_T, DIA_T, MES_T, ANO_T, SEGUNDOT_T, MINUTOT_T, HORAT_T  out  8 each  committed BCD values.
- SWEEP_DONE  out  1  one-cycle pulse on commit.

Behaviour:
- Reset (RST=0, async): all value outputs 8'h00; CS_N=RD_N=WR_N=AD_N=1; AD_OUT=0; AD_OE=0; BUS_GNT=0; SWEEP_DONE=0; refresh counter 0; pending=0; index=0; FSM=IDLE. A reset mid-transaction aborts it immediately and raises strobes; shadow contents are discarded.
- Refresh counter:
  - Free-running 0..REFRESH_CYC-1.
  - Wrap, or a START pulse, sets pending. Pending is a single flag, so extra requests while already pending are merged.
  - A request arriving during a sweep is kept and starts another sweep afterwards.
- Sweep order and addresses (index 0..8): 0x21 seg, 0x22 min, 0x23 hora, 0x24 dia, 0x25 mes, 0x26 ano, 0x41 segT, 0x42 minT, 0x43 horaT.
- FSM states: IDLE, ADDR, ADDR_HOLD, DATA, RECOVER, GRANT.
- IDLE:
  - BUS_REQ=1 → GRANT. BUS_REQ has priority over pending.
  - Else pending=1 → clear pending, index=0, → ADDR.
- ADDR (T_PULSE cycles): CS_N=0, AD_N=0, WR_N=0, AD_OE=1, AD_OUT=address.
- ADDR_HOLD (T_GAP cycles): WR_N=1; CS_N, AD_N, AD_OE and AD_OUT unchanged.
- DATA (T_PULSE cycles): AD_OE=0, AD_N=1, RD_N=0, CS_N=0. AD_IN is sampled into shadow[index] on the final cycle.
- RECOVER (T_GAP cycles): all strobes high, CS_N=1. On the final cycle:
  - If index=8: copy all shadows to the outputs in the same edge, pulse SWEEP_DONE, → IDLE.
  - Else: index+1; BUS_REQ=1 → GRANT, else → ADDR.
- GRANT:
  - BUS_GNT=1; all strobes high; AD_OE=0.
  - When BUS_REQ drops, BUS_GNT=0 on the next edge.
  - Return → ADDR if a sweep is in progress (resume at current index, shadows kept), else → IDLE.
- Transaction length is exactly 2·(T_PULSE+T_GAP) cycles. A full uninterrupted sweep is 9× that (144 cycles at defaults), measured from leaving IDLE to the SWEEP_DONE edge.
- Outputs are updated only at commit. The display never sees a mix of values from two sweeps.
- HORA_T and HORAT_T commit as {2'b00, data[5:0]}, masking the 12/24 flag bits. All other registers pass through raw; nibbles above 9 are not corrected.
- BUS_REQ is never granted mid-transaction. Worst-case grant latency is 2·(T_PULSE+T_GAP)+1 cycles.
- Timing counters are 8 bits wide; T_PULSE and T_GAP must be at least 1.

Decomposition:
- Shared package rtc_pkg:
  - RTC register address constants (0x21–0x26, 0x41–0x43).
  - Sweep index-to-address table.
  - FSM state encoding.
  - Hour mask constant.
- One natural sub-module, rtc_bus_cycle:
  - Single read-transaction engine (ADDR…RECOVER with timing counter).
  - Interface: go/addr in, done/data out.
  - The sequencer keeps the refresh, index, shadows, arbitration and commit.

Test Plan:
- Reset release, START pulse, RTC model returns 0x45,0x30,0x12,0x27,0x08,0x24,0x05,0x10,0x01 → first address 0x21 with WR_N low 4 cycles; SWEEP_DONE at cycle 144; outputs SEGUNDO_T=0x45 … HORAT_T=0x01, all changing on the same edge.
- Hours register returns 0xD2 → HORA_T=0x12, HORAT_T masked the same way.
- BUS_REQ raised during DATA phase of index 3 → BUS_GNT=1 only after RECOVER of index 3 ends; hold 20 cycles, drop → BUS_GNT=0 next edge; sweep resumes at address 0x25; outputs unchanged until the single SWEEP_DONE.
- START pulsed twice during a sweep → exactly one further sweep follows; SWEEP_DONE pulses twice in total.
- RST driven low mid-ADDR of index 5 → strobes high and outputs 0x00 asynchronously; after release no bus activity until the next START or refresh wrap.
- REFRESH_CYC=200, no START → sweeps begin every 200 cycles; AD_OE never 1 while RD_N=0.
